// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU result FIFO.
// Op codes, 37-bit entry layout and sticky flag bit indices.
package fpu_pkg;

  localparam int RES_W   = 32;
  localparam int OP_W    = 2;
  localparam int FLAG_W  = 3;
  localparam int ENTRY_W = OP_W + FLAG_W + RES_W;

  localparam int FLAG_EXC = 2;
  localparam int FLAG_OF  = 1;
  localparam int FLAG_UF  = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fpu_op_e;

  typedef struct packed {
    fpu_op_e          op;
    logic             exc;
    logic             of;
    logic             uf;
    logic [RES_W-1:0] result;
  } fpu_entry_t;

endpackage

// File: rtl/fpu_fifo_ptr.sv
// Read/write pointer and occupancy tracking for fpu_result_fifo.
// Ports: clk, rst, push_i/pop_i (qualified), wr_ptr_o, rd_ptr_o, count_o, full_o, empty_o.
module fpu_fifo_ptr #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    if (pop_i)  rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign wr_ptr_o = wr_q;
  assign rd_ptr_o = rd_q;
  assign count_o  = cnt_q;
  assign full_o   = (cnt_q == CW'(DEPTH));
  assign empty_o  = (cnt_q == '0);

endmodule

// File: rtl/fpu_result_fifo.sv
// Result FIFO between the FPU ALU and writeback: valid/ready in and out, head entry shown combinationally.
// Ports: in_* push side, out_* pop side, count, sticky_flags/sticky_clr (accumulate only with FPU_STICKY_FLAGS_EN).
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_exc,
  input  logic             in_of,
  input  logic             in_uf,
  input  logic [RES_W-1:0] in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_op,
  output logic             out_exc,
  output logic             out_of,
  output logic             out_uf,
  output logic [RES_W-1:0] out_result,
  output logic [CW-1:0]    count,
  output logic [2:0]       sticky_flags,
  input  logic             sticky_clr
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  fpu_entry_t    wr_entry;
  fpu_entry_t    head;
  fpu_entry_t    mem_q [DEPTH];

  // Full blocks pushes even when a pop happens the same cycle.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_ready & ~empty;

  fpu_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .pop_i    (pop),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign wr_entry = '{
    op:     fpu_op_e'(in_op),
    exc:    in_exc,
    of:     in_of,
    uf:     in_uf,
    result: in_result
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr] <= wr_entry;
    end
  end

  // Head is visible even when empty; it is then stale and ignored.
  assign head       = mem_q[rd_ptr];
  assign out_op     = head.op;
  assign out_exc    = head.exc;
  assign out_of     = head.of;
  assign out_uf     = head.uf;
  assign out_result = head.result;

`ifdef FPU_STICKY_FLAGS_EN
  logic [2:0] sticky_q;
  logic [2:0] sticky_d;
  logic [2:0] push_flags;

  always_comb begin
    push_flags = '0;
    if (push) begin
      push_flags[FLAG_EXC] = in_exc;
      push_flags[FLAG_OF]  = in_of;
      push_flags[FLAG_UF]  = in_uf;
    end
    // Clear wins over history but not over the same-cycle push.
    sticky_d = sticky_clr ? push_flags : (sticky_q | push_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = '0;
`endif

endmodule
